// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache tag controller:
// address split, tag-RAM entry layout and controller state encoding.
package icache_pkg;

    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 3;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int DEPTH    = 1 << INDEX_W;

    // One tag-RAM word: valid bit on top, tag below.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31 -: TAG_W];
    endfunction

endpackage

// File: rtl/icache_tag_flush_cnt.sv
// Index walker used while the tag array is being cleared. Steps through
// every set once; restart rewinds to set 0 for the following cycle and
// done marks the cycle in which the last set is being written.
module icache_tag_flush_cnt
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               en,
    output logic [INDEX_W-1:0] cnt,
    output logic               done
);

    // Advance one set per enabled cycle; wraps to 0 after the last set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = en && !restart && (cnt == '1);

endmodule

// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag controller: clears the tag array after reset or on
// invalidate, writes refill tags, and runs a two-cycle lookup pipeline
// (RAM read issue, then compare) with forwarding from a same-cycle refill.
module icache_tag_ctrl
    import icache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic [31:0]        req_pc_i,
    output logic               req_ready_o,
    input  logic               refill_valid_i,
    input  logic [31:0]        refill_pc_i,
    output logic               refill_ready_o,
    input  logic               invalidate_i,
    output logic               busy_o,
    output logic               rsp_valid_o,
    output logic               rsp_hit_o,
    output logic [31:0]        rsp_pc_o,
    output logic               tag_csb0_o,
    output logic [INDEX_W-1:0] tag_addr0_o,
    output logic [TAG_W:0]     tag_din0_o,
    output logic               tag_csb1_o,
    output logic [INDEX_W-1:0] tag_addr1_o,
    input  logic [TAG_W:0]     tag_dout1_i
);

    state_e             state;
    logic               flush_st;
    logic               flush_wr;
    logic [INDEX_W-1:0] flush_cnt;
    logic               flush_done;
    logic               refill_acc;
    logic               req_acc;
    tag_entry_t         wr_entry;
    tag_entry_t         rd_entry;

    logic               vld_p1;
    logic [31:0]        pc_p1;
    logic               fwd_p1;
    logic               kill_p1;
    logic               hit_p1;

    // Offset bits of the refill address carry no information for the tag array.
    logic               unused_refill_offset;
    assign unused_refill_offset = ^refill_pc_i[OFFSET_W-1:0];

    assign flush_st = (state == FLUSH);
    // Flush writes are held off while reset is asserted so the RAM port idles.
    assign flush_wr = flush_st && rst_ni;

    icache_tag_flush_cnt u_flush_cnt (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .restart (invalidate_i),
        .en      (flush_st),
        .cnt     (flush_cnt),
        .done    (flush_done)
    );

    // Controller state: invalidate always (re)starts a flush; the flush ends after the last set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= FLUSH;
        end else if (invalidate_i) begin
            state <= FLUSH;
        end else if (flush_st && flush_done) begin
            state <= RUN;
        end
    end

    // Refill wins over lookup so the write and read ports are never both selected.
    assign busy_o         = flush_st;
    assign refill_ready_o = (state == RUN) && !invalidate_i;
    assign req_ready_o    = refill_ready_o && !refill_valid_i;
    assign refill_acc     = refill_valid_i && refill_ready_o;
    assign req_acc        = req_valid_i && req_ready_o;

    // Write port: flush clears entries, otherwise an accepted refill installs a valid tag.
    always_comb begin
        tag_csb0_o  = 1'b1;
        tag_addr0_o = '0;
        wr_entry    = '0;
        if (flush_wr) begin
            tag_csb0_o  = 1'b0;
            tag_addr0_o = flush_cnt;
        end else if (refill_acc) begin
            tag_csb0_o     = 1'b0;
            tag_addr0_o    = pc_index(refill_pc_i);
            wr_entry.valid = 1'b1;
            wr_entry.tag   = pc_tag(refill_pc_i);
        end
    end

    assign tag_din0_o  = wr_entry;
    assign tag_csb1_o  = !req_acc;
    assign tag_addr1_o = req_acc ? pc_index(req_pc_i) : '0;

    // ---- stage 1: lookup accepted, RAM read in flight ----
    // Lookup occupancy; reset drops any lookup in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= req_acc;
        end
    end

    // PC of the lookup in flight; only meaningful alongside vld_p1.
    always_ff @(posedge clk_i) begin
        if (req_acc) begin
            pc_p1 <= req_pc_i;
        end
    end

    // A refill to the same set this cycle is newer than what the RAM returned.
    assign rd_entry = tag_entry_t'(tag_dout1_i);
    assign fwd_p1   = refill_acc && (pc_index(refill_pc_i) == pc_index(pc_p1));
    assign kill_p1  = invalidate_i || flush_st;
    assign hit_p1   = fwd_p1 ? (pc_tag(refill_pc_i) == pc_tag(pc_p1))
                             : (rd_entry.valid && (rd_entry.tag == pc_tag(pc_p1)));

    // ---- stage 2: registered lookup response ----
    // One-cycle response pulse; a flush starting or in progress forces a miss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_pc_o    <= '0;
        end else begin
            rsp_valid_o <= vld_p1;
            rsp_hit_o   <= vld_p1 && hit_p1 && !kill_p1;
            if (vld_p1) begin
                rsp_pc_o <= pc_p1;
            end
        end
    end

endmodule
